// File: rtl/quad_step_decoder_if.sv
// Decoder-to-counter bundle: step pulses, direction, position, error and index.
// Driven combinationally from registered decoder state; no backpressure (pulses are fire-and-forget).
interface quad_step_decoder_if #(
  parameter int CNT_W = 8
);
  logic             step_en;
  logic             step_up;
  logic [CNT_W-1:0] position;
  logic             err;
  logic             idx_hit;

  modport master (output step_en, output step_up, output position, output err, output idx_hit);
  modport slave  (input  step_en, input  step_up, input  position, input  err, input  idx_hit);
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: sync + glitch filter + Gray-step FSM feeding an up/down counter (index zeroing under QUAD_INDEX_EN).
// Latency: raw edge to step_en is SYNC_STAGES+FILT_LEN+1 cycles (6 at defaults).
// No backpressure: step_en/idx_hit are single-cycle pulses; ena low suppresses them and freezes position.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                quad_a,
  input  logic                quad_b,
  input  logic                idx,
  input  logic                clr,
  quad_step_decoder_if.master dec
);

  localparam int FW = $clog2(FILT_LEN + 1);

`ifdef QUAD_INDEX_EN
  localparam int NCH = 3;
  logic [NCH-1:0] raw;
  assign raw = {idx, quad_b, quad_a};
`else
  localparam int NCH = 2;
  logic [NCH-1:0] raw;
  logic           unused_idx;
  assign raw        = {quad_b, quad_a};
  assign unused_idx = idx;
`endif

  typedef enum logic {INIT, TRACK} state_t;
  state_t state_q, state_d;

  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NCH-1:0][FW-1:0]          fcnt_q, fcnt_d;
  logic [NCH-1:0]                  sync_v, filt_q, filt_d, prev_q;
  logic [FW-1:0]                   init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]                pos_q;
  logic                            step_en_q, step_up_q, err_q;
  logic                            load, step_vld, step_dir, illegal, idx_evt;
  logic [1:0]                      ph_prev, ph_cur, ph_diff;

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) sync_v[ch] = sync_q[ch][SYNC_STAGES-1];
  end

  // Gray {A,B} -> binary phase so that +1 mod 4 is an up step and +3 a down step.
  assign ph_prev = {prev_q[0], prev_q[0] ^ prev_q[1]};
  assign ph_cur  = {filt_q[0], filt_q[0] ^ filt_q[1]};
  assign ph_diff = ph_cur - ph_prev;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    filt_d     = filt_q;
    fcnt_d     = fcnt_q;
    load       = 1'b0;
    step_vld   = 1'b0;
    step_dir   = 1'b0;
    illegal    = 1'b0;
    idx_evt    = 1'b0;
    case (state_q)
      INIT: begin
        fcnt_d = '0;
        if (init_cnt_q == FW'(FILT_LEN - 1)) begin
          state_d = TRACK;
          filt_d  = sync_v;
          load    = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      TRACK: begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (sync_v[ch] != filt_q[ch]) begin
            if (fcnt_q[ch] == FW'(FILT_LEN - 1)) begin
              filt_d[ch] = ~filt_q[ch];
              fcnt_d[ch] = '0;
            end else begin
              fcnt_d[ch] = fcnt_q[ch] + 1'b1;
            end
          end else begin
            fcnt_d[ch] = '0;
          end
        end
        step_vld = ena && ((ph_diff == 2'd1) || (ph_diff == 2'd3));
        step_dir = (ph_diff == 2'd1);
        illegal  = ena && (ph_diff == 2'd2);
`ifdef QUAD_INDEX_EN
        idx_evt  = ena && filt_q[2] && !prev_q[2] && (filt_q[1:0] == 2'b00);
`endif
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      sync_q     <= '0;
      fcnt_q     <= '0;
      filt_q     <= '0;
      prev_q     <= '0;
      step_en_q  <= 1'b0;
      step_up_q  <= 1'b0;
      err_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      fcnt_q     <= fcnt_d;
      filt_q     <= filt_d;
      for (int ch = 0; ch < NCH; ch++)
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
      // Seeding prev with the same snapshot as filt makes the INIT exit step-free.
      prev_q     <= load ? sync_v : filt_q;
      step_en_q  <= step_vld;
      if (step_vld) step_up_q <= step_dir;
      if (clr || idx_evt)  pos_q <= '0;
      else if (step_vld)   pos_q <= step_dir ? pos_q + 1'b1 : pos_q - 1'b1;
      if (clr)             err_q <= 1'b0;
      else if (illegal)    err_q <= 1'b1;
    end
  end

`ifdef QUAD_INDEX_EN
  logic idx_hit_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_hit_q <= 1'b0;
    else        idx_hit_q <= idx_evt;
  end
  assign dec.idx_hit = idx_hit_q;
`else
  assign dec.idx_hit = 1'b0;
`endif

  assign dec.step_en  = step_en_q;
  assign dec.step_up  = step_up_q;
  assign dec.position = pos_q;
  assign dec.err      = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: vector table of phase changes plus glitch/clr/reset/index sequences.
module tb_quad_step_decoder;

  logic clk, rst_n, ena, quad_a, quad_b, idx, clr;
  int   checks, errors;

  quad_step_decoder_if #(.CNT_W(8)) dif ();

  quad_step_decoder #(.SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .quad_a(quad_a), .quad_b(quad_b),
    .idx(idx), .clr(clr), .dec(dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ab;     // {A,B}
    logic       ena;
    logic       clr;    // asserted for the first cycle only
    int         steps;
    logic       up;
    logic [7:0] pos;
    logic       err;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [1:0] ab, input logic en, input logic cl, input int steps,
                     input logic up, input logic [7:0] pos, input logic er);
    vec_t v;
    v.ab = ab; v.ena = en; v.clr = cl; v.steps = steps; v.up = up; v.pos = pos; v.err = er;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Runs n cycles, counting step/idx pulses and recording when the first of each appeared.
  task automatic run(input int n, output int np, output int pfirst, output logic up,
                     output int ni, output int ifirst);
    np = 0; pfirst = 0; up = 1'b0; ni = 0; ifirst = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      clr = 1'b0;
      if (dif.step_en) begin
        np++;
        if (pfirst == 0) begin pfirst = k; up = dif.step_up; end
      end
      if (dif.idx_hit) begin
        ni++;
        if (ifirst == 0) ifirst = k;
      end
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  int   np, pf, ni, inf;
  logic up;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b1; ena = 1'b1; quad_a = 1'b1; quad_b = 1'b1; idx = 1'b0; clr = 1'b0;

    add(2'b11, 1, 0, 0, 0, 8'd0,   0);
    add(2'b10, 1, 0, 1, 1, 8'd1,   0);
    add(2'b00, 1, 0, 1, 1, 8'd2,   0);
    add(2'b10, 1, 0, 1, 0, 8'd1,   0);
    add(2'b11, 1, 0, 1, 0, 8'd0,   0);
    add(2'b01, 1, 0, 1, 0, 8'd255, 0);
    add(2'b00, 1, 0, 1, 0, 8'd254, 0);
    add(2'b01, 1, 0, 1, 1, 8'd255, 0);
    add(2'b11, 1, 0, 1, 1, 8'd0,   0);
    add(2'b10, 1, 0, 1, 1, 8'd1,   0);
    add(2'b00, 1, 0, 1, 1, 8'd2,   0);
    add(2'b00, 1, 1, 0, 0, 8'd0,   0);
    add(2'b01, 1, 0, 1, 1, 8'd1,   0);
    add(2'b11, 1, 0, 1, 1, 8'd2,   0);
    add(2'b10, 1, 0, 1, 1, 8'd3,   0);
    add(2'b00, 1, 0, 1, 1, 8'd4,   0);
    add(2'b11, 1, 0, 0, 0, 8'd4,   1);
    add(2'b11, 1, 1, 0, 0, 8'd0,   0);
    add(2'b10, 0, 0, 0, 0, 8'd0,   0);
    add(2'b00, 0, 0, 0, 0, 8'd0,   0);
    add(2'b01, 0, 0, 0, 0, 8'd0,   0);
    add(2'b01, 1, 0, 0, 0, 8'd0,   0);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_step_en",  dif.step_en,  0);
    chk("rst_step_up",  dif.step_up,  0);
    chk("rst_position", dif.position, 0);
    chk("rst_err",      dif.err,      0);
    chk("rst_idx_hit",  dif.idx_hit,  0);
    tick(2);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      quad_a = tv[i].ab[1]; quad_b = tv[i].ab[0]; ena = tv[i].ena; clr = tv[i].clr;
      run(10, np, pf, up, ni, inf);
      chk($sformatf("v%0d_pulses", i), np, tv[i].steps);
      if (tv[i].steps > 0) begin
        chk($sformatf("v%0d_latency", i), pf, 6);
        chk($sformatf("v%0d_step_up", i), up, tv[i].up);
      end
      chk($sformatf("v%0d_position", i), dif.position, tv[i].pos);
      chk($sformatf("v%0d_err", i), dif.err, tv[i].err);
    end

    // Two-cycle glitch on A from 01 must be filtered out.
    quad_a = 1'b1; tick(2); quad_a = 1'b0;
    run(12, np, pf, up, ni, inf);
    chk("glitch_pulses",   np, 0);
    chk("glitch_position", dif.position, 0);

    // clr landing on the same edge as a step: step reported, position cleared.
    quad_a = 1'b1;
    tick(5);
    clr = 1'b1;
    tick(1);
    chk("clr_step_en",  dif.step_en,  1);
    chk("clr_step_up",  dif.step_up,  1);
    chk("clr_position", dif.position, 0);
    clr = 1'b0;
    tick(1);
    chk("clr_step_en_gone", dif.step_en, 0);

    // clr on the same edge as an illegal 11->00 jump keeps err low.
    quad_a = 1'b0; quad_b = 1'b0;
    tick(5);
    clr = 1'b1;
    tick(1);
    chk("clr_ill_err",     dif.err,     0);
    chk("clr_ill_step_en", dif.step_en, 0);
    clr = 1'b0;
    tick(3);
    chk("clr_ill_err_late", dif.err,      0);
    chk("clr_ill_position", dif.position, 0);

    // Reset mid-operation, then no step leaving INIT.
    quad_b = 1'b1;
    run(10, np, pf, up, ni, inf);
    chk("pre_rst_position", dif.position, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_position", dif.position, 0);
    chk("mid_rst_step_up",  dif.step_up,  0);
    chk("mid_rst_step_en",  dif.step_en,  0);
    tick(2);
    rst_n = 1'b1;
    run(12, np, pf, up, ni, inf);
    chk("post_rst_pulses",   np, 0);
    chk("post_rst_position", dif.position, 0);
    chk("post_rst_err",      dif.err,      0);

`ifdef QUAD_INDEX_EN
    quad_b = 1'b0;
    run(10, np, pf, up, ni, inf);
    chk("idx_pre_position", dif.position, 255);
    idx = 1'b1;
    run(10, np, pf, up, ni, inf);
    chk("idx_hit_pulses",  ni,  1);
    chk("idx_hit_latency", inf, 6);
    chk("idx_position",    dif.position, 0);
    idx = 1'b0;
    tick(8);
    quad_b = 1'b1;
    run(10, np, pf, up, ni, inf);
    chk("idx_off_pre_position", dif.position, 1);
    idx = 1'b1;
    run(12, np, pf, up, ni, inf);
    chk("idx_off_pulses",   ni, 0);
    chk("idx_off_position", dif.position, 1);
`else
    idx = 1'b1;
    run(12, np, pf, up, ni, inf);
    chk("idx_disabled_pulses", ni, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Quadrature decoder: the source side of the up/down counter interface.
- Turns two-channel encoder inputs (A/B) into the count-enable and direction pulses that feed an up/down counter.
- Also keeps its own wrap-around position register and a sticky illegal-transition flag.
- Sits between the ui_in pads and the counter/uo_out logic in the top-level wrapper.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per input channel (min 2).
- FILT_LEN, 3: consecutive identical synchronized samples required before a filtered channel changes (min 1).
- CNT_W, 8: width of the position register.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  decoder enable; low freezes the position and suppresses steps
- quad_a  input  1  raw encoder channel A (asynchronous)
- quad_b  input  1  raw encoder channel B (asynchronous)
- idx  input  1  raw encoder index (asynchronous; used only with the optional feature)
- clr  input  1  synchronous clear of position and err
- step_en  output  1  one-cycle pulse per valid quadrature transition
- step_up  output  1  direction of the current step: 1 = up, 0 = down; held between steps
- position  output  CNT_W  accumulated signed-agnostic count
- err  output  1  sticky illegal-transition flag
- idx_hit  output  1  one-cycle pulse on an index event

Behaviour:
- Reset (rst_n low, asynchronous): all sync/filter flops, step_en, step_up, position, err and idx_hit go to 0; FSM enters INIT.
- Synchronizer: each raw input passes through SYNC_STAGES flops.
- Filter, per channel:
  - a counter counts cycles where the synchronized value differs from the filtered value;
  - any agreeing sample resets the counter;
  - when the counter reaches FILT_LEN, the filtered value flips and the counter clears.
- FSM states: INIT, TRACK.
  - INIT: waits FILT_LEN cycles after reset release, then copies the synchronized {A,B} into the filtered state without a step or error, and moves to TRACK.
  - TRACK: compares the previous filtered {A,B} with the current filtered {A,B} each cycle.
- Gray sequence and step decisions (in TRACK):
  - Up sequence is 00->01->11->10->00; the reverse order is down.
  - Single-bit change in the up order: step_en=1, step_up=1, position+1.
  - Single-bit change in the reverse order: step_en=1, step_up=0, position-1.
  - Both bits change in the same cycle: err <= 1 (sticky), no step, position unchanged; tracking continues from the new state.
- Latency: a raw input change held stable produces step_en high on the (SYNC_STAGES+FILT_LEN+1)-th rising edge after the first edge that samples the new value. This is 6 at default parameters.
- step_en is registered and never high for more than one consecutive cycle per transition.
- position arithmetic is modulo 2^CNT_W:
  - all-ones +1 -> 0;
  - 0 -1 -> all-ones.
- ena low:
  - step_en and idx_hit forced 0;
  - position held;
  - sync, filter and the previous-state register keep tracking, so re-enable causes no spurious step.
- clr high:
  - position <= 0 and err <= 0 at the next edge;
  - clr has priority over a simultaneous step (position = 0 afterwards), but step_en/step_up still report that step;
  - clr coincident with an illegal transition leaves err = 0.
- Reset mid-operation: immediate return to reset values and INIT; no step on exit from INIT.

Optional Feature:
- Macro: QUAD_INDEX_EN.
- Defined:
  - idx is synchronized and filtered like the A/B channels;
  - a rising edge of the filtered idx while the filtered {A,B} = 00 and ena = 1 zeroes position and pulses idx_hit for one cycle;
  - an index event overrides a step in the same cycle (position = 0);
  - a filtered idx rise with {A,B} != 00 is ignored.
- Undefined: idx is unused (listed in the unused-signal sink), idx_hit is tied 0, and no index logic is generated.

Test Plan:
- Reset release with A=B=1, wait 10 cycles -> step_en never pulses, err=0, position=0.
- From 00, apply up sequence 01,11,10,00 with each phase held 10 cycles -> 4 step_en pulses, each with step_up=1, 6 cycles after its change; position=4.
- From position=2, apply down sequence 10,11,01,00 -> 4 pulses with step_up=0, position=254 (CNT_W=8).
- Jump 00->11 in one input edge -> err=1, no step_en, position unchanged; then clr pulse -> err=0, position=0.
- Glitch on A lasting 2 cycles (FILT_LEN=3) -> no step_en; with ena=0, 3 up transitions -> position unchanged, and no step after ena returns to 1.
- With QUAD_INDEX_EN, position=7 and {A,B}=00, raise idx -> idx_hit one-cycle pulse and position=0; raise idx at {A,B}=01 -> no effect.
